alu_rs: RTL and testbench

- Reservation station directly upstream of the integer ALU.
- Buffers decoded ALU/branch-compare ops from the dispatcher until both operands are available.
- Snoops two result buses (ALU and load/store) for missing operands; dispatches at most one ready op per cycle to the ALU.
- ALU input registers are driven from registered outputs, so the ALU sees a clean valid/operand set every cycle.

---
 rtl/alu_rs_pkg.sv | 69 ++++++
 rtl/alu_rs_if.sv | 49 ++++
 rtl/alu_rs_pick.sv | 33 +++
 rtl/alu_rs.sv | 154 +++++++++++++++
 tb/tb_alu_rs.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the integer ALU and the stations that feed it:
// work_type layout, tag/word widths, the station entry record and the
// operand wakeup helper.
package alu_rs_pkg;

  localparam int ROB_W      = 2;
  localparam int XLEN       = 32;
  localparam int WT_W       = 5;
  localparam int WT_BR_BIT  = 4;  // branch compare
  localparam int WT_SUB_BIT = 3;  // subtract / arithmetic variant
  localparam int WT_FN_W    = 3;  // function select in [2:0]

  typedef logic [ROB_W-1:0] rob_tag_t;
  typedef logic [XLEN-1:0]  word_t;
  typedef logic [WT_W-1:0]  work_type_t;

  typedef struct packed {
    logic       busy;
    work_type_t work_type;
    word_t      vj;
    word_t      vk;
    rob_tag_t   qj;
    rob_tag_t   qk;
    logic       qj_pend;
    logic       qk_pend;
    rob_tag_t   rob_id;
  } rs_entry_t;

  // One operand slot after looking at both result buses.
  typedef struct packed {
    logic  pend;
    word_t val;
  } opnd_t;

  // Assemble a work_type from its fields.
  function automatic work_type_t mk_work_type(input logic br, input logic sub,
                                              input logic [WT_FN_W-1:0] fn);
    work_type_t wt;
    wt = '0;
    wt[WT_BR_BIT] = br;
    wt[WT_SUB_BIT] = sub;
    wt[WT_FN_W-1:0] = fn;
    return wt;
  endfunction

  // Resolve a pending operand against the two result buses; the ALU bus
  // wins if both carry the same tag.
  function automatic opnd_t wake_opnd(input logic pend, input rob_tag_t q, input word_t v,
                                      input logic c0_valid, input rob_tag_t c0_tag,
                                      input word_t c0_val,
                                      input logic c1_valid, input rob_tag_t c1_tag,
                                      input word_t c1_val);
    opnd_t r;
    r.pend = pend;
    r.val  = v;
    if (pend && c0_valid && (c0_tag == q)) begin
      r.pend = 1'b0;
      r.val  = c0_val;
    end else if (pend && c1_valid && (c1_tag == q)) begin
      r.pend = 1'b0;
      r.val  = c1_val;
    end else begin
      r.pend = pend;
      r.val  = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatcher-side, result-bus and ALU-side signals of the ALU reservation
// station. master = the surrounding pipeline, slave = the station.
interface alu_rs_if
  import alu_rs_pkg::*;
#(
  parameter int ROB_W = 2
) ();

  logic              in_valid;
  logic [WT_W-1:0]   in_work_type;
  logic [XLEN-1:0]   in_vj;
  logic [XLEN-1:0]   in_vk;
  logic [ROB_W-1:0]  in_qj;
  logic [ROB_W-1:0]  in_qk;
  logic              in_qj_pend;
  logic              in_qk_pend;
  logic [ROB_W-1:0]  in_rob_id;
  logic              full;

  logic              cdb0_valid;
  logic [ROB_W-1:0]  cdb0_rob_id;
  logic [XLEN-1:0]   cdb0_value;
  logic              cdb1_valid;
  logic [ROB_W-1:0]  cdb1_rob_id;
  logic [XLEN-1:0]   cdb1_value;

  logic              alu_valid;
  logic [WT_W-1:0]   alu_work_type;
  logic [XLEN-1:0]   alu_r1;
  logic [XLEN-1:0]   alu_r2;
  logic [ROB_W-1:0]  alu_rob_id;

  modport master (
    output in_valid, in_work_type, in_vj, in_vk, in_qj, in_qk,
           in_qj_pend, in_qk_pend, in_rob_id,
           cdb0_valid, cdb0_rob_id, cdb0_value,
           cdb1_valid, cdb1_rob_id, cdb1_value,
    input  full, alu_valid, alu_work_type, alu_r1, alu_r2, alu_rob_id
  );

  modport slave (
    input  in_valid, in_work_type, in_vj, in_vk, in_qj, in_qk,
           in_qj_pend, in_qk_pend, in_rob_id,
           cdb0_valid, cdb0_rob_id, cdb0_value,
           cdb1_valid, cdb1_rob_id, cdb1_value,
    output full, alu_valid, alu_work_type, alu_r1, alu_r2, alu_rob_id
  );

endinterface

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module rs_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i);
      end else begin
        w_found = w_found;
        w_idx   = w_idx;
      end
    end
  end

  assign o_found = w_found;
  assign o_idx   = w_idx;

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU. Holds ops until both
// operands are known, snoops the ALU and load/store result buses, and
// hands at most one ready op per cycle to the ALU through registers.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int ROB_W   = alu_rs_pkg::ROB_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     flush,
  alu_rs_if.slave  bus
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t        r_ent [RS_SIZE];
  logic             r_alu_valid;
  work_type_t       r_alu_work_type;
  word_t            r_alu_r1;
  word_t            r_alu_r2;
  logic [ROB_W-1:0] r_alu_rob_id;

  rs_entry_t        w_nxt [RS_SIZE];
  opnd_t            w_wj  [RS_SIZE];
  opnd_t            w_wk  [RS_SIZE];
  logic [RS_SIZE-1:0] w_free;
  logic [RS_SIZE-1:0] w_ready;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_rdy_found;
  logic [IDX_W-1:0] w_rdy_idx;
  logic             w_issue;
  opnd_t            w_bj;
  opnd_t            w_bk;
  rs_entry_t        w_new;

  // Per-entry status and operand wakeup against both result buses.
  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    assign w_free[g]  = ~r_ent[g].busy;
    assign w_ready[g] = r_ent[g].busy & ~r_ent[g].qj_pend & ~r_ent[g].qk_pend;
    assign w_wj[g] = wake_opnd(r_ent[g].qj_pend, r_ent[g].qj, r_ent[g].vj,
                               bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                               bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);
    assign w_wk[g] = wake_opnd(r_ent[g].qk_pend, r_ent[g].qk, r_ent[g].vk,
                               bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                               bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);
  end

  rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
    .i_req   (w_free),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
    .i_req   (w_ready),
    .o_found (w_rdy_found),
    .o_idx   (w_rdy_idx)
  );

  // Full is judged on pre-edge state, so a same-cycle dispatch never
  // frees a slot for the op presented in that cycle.
  assign bus.full = ~w_free_found;
  assign w_issue  = bus.in_valid & w_free_found;

  // Incoming operands may be resolved by a result broadcast in the same cycle.
  assign w_bj = wake_opnd(bus.in_qj_pend, bus.in_qj, bus.in_vj,
                          bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                          bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);
  assign w_bk = wake_opnd(bus.in_qk_pend, bus.in_qk, bus.in_vk,
                          bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value,
                          bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value);

  // Build the entry written on issue.
  always_comb begin
    w_new           = '0;
    w_new.busy      = 1'b1;
    w_new.work_type = bus.in_work_type;
    w_new.vj        = w_bj.val;
    w_new.vk        = w_bk.val;
    w_new.qj        = bus.in_qj;
    w_new.qk        = bus.in_qk;
    w_new.qj_pend   = w_bj.pend;
    w_new.qk_pend   = w_bk.pend;
    w_new.rob_id    = bus.in_rob_id;
  end

  // Next state of every entry: wakeup, then dispatch release, then issue.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_nxt[i] = r_ent[i];
      if (r_ent[i].busy) begin
        w_nxt[i].qj_pend = w_wj[i].pend;
        w_nxt[i].vj      = w_wj[i].val;
        w_nxt[i].qk_pend = w_wk[i].pend;
        w_nxt[i].vk      = w_wk[i].val;
      end else begin
        w_nxt[i].busy = 1'b0;
      end
      if (w_rdy_found && (w_rdy_idx == IDX_W'(i))) begin
        w_nxt[i].busy = 1'b0;
      end else begin
        w_nxt[i].busy = w_nxt[i].busy;
      end
      if (w_issue && (w_free_idx == IDX_W'(i))) begin
        w_nxt[i] = w_new;
      end else begin
        w_nxt[i] = w_nxt[i];
      end
    end
  end

  // Station state and ALU-facing registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_ent[i] <= '0;
      end
      r_alu_valid     <= 1'b0;
      r_alu_work_type <= '0;
      r_alu_r1        <= '0;
      r_alu_r2        <= '0;
      r_alu_rob_id    <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          r_ent[i] <= '0;
        end
        r_alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          r_ent[i] <= w_nxt[i];
        end
        r_alu_valid <= w_rdy_found;
        if (w_rdy_found) begin
          r_alu_work_type <= r_ent[w_rdy_idx].work_type;
          r_alu_r1        <= r_ent[w_rdy_idx].vj;
          r_alu_r2        <= r_ent[w_rdy_idx].vk;
          r_alu_rob_id    <= r_ent[w_rdy_idx].rob_id;
        end
      end
    end
  end

  assign bus.alu_valid     = r_alu_valid;
  assign bus.alu_work_type = r_alu_work_type;
  assign bus.alu_r1        = r_alu_r1;
  assign bus.alu_r2        = r_alu_r2;
  assign bus.alu_rob_id    = r_alu_rob_id;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, ready issue, wakeup, full boundary,
// issue-time bypass, freeze/flush and reset mid-operation.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;

  alu_rs_if #(.ROB_W(2)) bus ();

  alu_rs #(.RS_SIZE(4), .ROB_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Upstream protocol watch: an op offered to a full, live station.
  always @(negedge clk) begin
    if (rst && rdy && !flush && bus.in_valid && bus.full) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_alu(input string tag, input logic v, input logic [4:0] wt,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [1:0] rob);
    chk({tag, ".valid"}, {31'd0, bus.alu_valid}, {31'd0, v});
    chk({tag, ".wt"},    {27'd0, bus.alu_work_type}, {27'd0, wt});
    chk({tag, ".r1"},    bus.alu_r1, r1);
    chk({tag, ".r2"},    bus.alu_r2, r2);
    chk({tag, ".rob"},   {30'd0, bus.alu_rob_id}, {30'd0, rob});
  endtask

  task automatic chk_v(input string tag, input logic v);
    chk(tag, {31'd0, bus.alu_valid}, {31'd0, v});
  endtask

  task automatic chk_full(input string tag, input logic f);
    chk(tag, {31'd0, bus.full}, {31'd0, f});
  endtask

  task automatic put_op(input logic [4:0] wt, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [1:0] qj, input logic qjp, input logic [1:0] qk,
                        input logic qkp, input logic [1:0] rob);
    bus.in_valid     = 1'b1;
    bus.in_work_type = wt;
    bus.in_vj        = vj;
    bus.in_vk        = vk;
    bus.in_qj        = qj;
    bus.in_qj_pend   = qjp;
    bus.in_qk        = qk;
    bus.in_qk_pend   = qkp;
    bus.in_rob_id    = rob;
  endtask

  task automatic cdb_idle();
    bus.cdb0_valid  = 1'b0;
    bus.cdb0_rob_id = 2'd0;
    bus.cdb0_value  = 32'd0;
    bus.cdb1_valid  = 1'b0;
    bus.cdb1_rob_id = 2'd0;
    bus.cdb1_value  = 32'd0;
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    put_op(5'd0, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    bus.in_valid = 1'b0;
    cdb_idle();

    // Reset state
    tick();
    tick();
    chk_alu("reset", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
    chk_full("reset.full", 1'b0);
    rst = 1'b1;

    // Ready issue: add 5+7, rob 1
    put_op(5'b00000, 32'd5, 32'd7, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_v("ready.issue_edge", 1'b0);
    tick();
    chk_alu("ready.disp", 1'b1, 5'b00000, 32'd5, 32'd7, 2'd1);
    tick();
    chk_v("ready.after", 1'b0);
    chk("ready.hold_r1", bus.alu_r1, 32'd5);

    // Dependency wakeup through cdb0
    put_op(mk_work_type(1'b0, 1'b1, 3'b000), 32'd0, 32'd3, 2'd2, 1'b1, 2'd0, 1'b0, 2'd3);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk_v("wake.waiting", 1'b0);
    bus.cdb0_valid = 1'b1; bus.cdb0_rob_id = 2'd2; bus.cdb0_value = 32'd10;
    tick();
    cdb_idle();
    chk_v("wake.wake_edge", 1'b0);
    tick();
    chk_alu("wake.disp", 1'b1, 5'b01000, 32'd10, 32'd3, 2'd3);

    // Full boundary: four entries waiting on tag 3
    for (int i = 0; i < 4; i++) begin
      put_op(5'b00000, 32'd0, 32'd100 + 32'(i), 2'd3, 1'b1, 2'd0, 1'b0, 2'(i));
      tick();
      if (i == 2) chk_full("full.three", 1'b0);
    end
    chk_full("full.four", 1'b1);
    put_op(5'b00000, 32'h55, 32'h56, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    bus.in_valid = 1'b0;
    chk_full("full.fifth", 1'b1);
    chk_v("full.fifth_nodisp", 1'b0);
    bus.cdb1_valid = 1'b1; bus.cdb1_rob_id = 2'd3; bus.cdb1_value = 32'd9;
    tick();
    cdb_idle();
    chk_v("full.wake_edge", 1'b0);
    chk_full("full.wake_full", 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_alu($sformatf("full.disp%0d", i), 1'b1, 5'b00000, 32'd9, 32'd100 + 32'(i), 2'(i));
      if (i == 0) chk_full("full.drop", 1'b0);
    end
    tick();
    chk_v("full.drained", 1'b0);

    // Issue-time bypass from cdb0
    put_op(mk_work_type(1'b1, 1'b0, 3'b001), 32'd0, 32'd4, 2'd0, 1'b1, 2'd0, 1'b0, 2'd2);
    bus.cdb0_valid = 1'b1; bus.cdb0_rob_id = 2'd0; bus.cdb0_value = 32'hFFFF_FFFF;
    tick();
    bus.in_valid = 1'b0;
    cdb_idle();
    chk_v("bypass.issue_edge", 1'b0);
    tick();
    chk_alu("bypass.disp", 1'b1, 5'b10001, 32'hFFFF_FFFF, 32'd4, 2'd2);

    // Same tag on both buses: cdb0 wins
    put_op(5'b00000, 32'd0, 32'd0, 2'd1, 1'b1, 2'd1, 1'b1, 2'd1);
    bus.cdb0_valid = 1'b1; bus.cdb0_rob_id = 2'd1; bus.cdb0_value = 32'hA;
    bus.cdb1_valid = 1'b1; bus.cdb1_rob_id = 2'd1; bus.cdb1_value = 32'hB;
    tick();
    bus.in_valid = 1'b0;
    cdb_idle();
    tick();
    chk_alu("tie.disp", 1'b1, 5'b00000, 32'hA, 32'hA, 2'd1);
    tick();
    chk_v("tie.after", 1'b0);

    // Freeze with rdy low, then flush
    put_op(5'b00000, 32'd0, 32'h40, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    put_op(5'b00000, 32'd0, 32'h41, 2'd2, 1'b1, 2'd0, 1'b0, 2'd1);
    tick();
    put_op(5'b00000, 32'h33, 32'h42, 2'd0, 1'b0, 2'd0, 1'b0, 2'd3);
    tick();
    chk_v("frz.pre", 1'b0);
    bus.in_valid = 1'b0;
    bus.cdb0_valid = 1'b1; bus.cdb0_rob_id = 2'd2; bus.cdb0_value = 32'h77;
    tick();
    chk_alu("frz.disp", 1'b1, 5'b00000, 32'h33, 32'h42, 2'd3);
    cdb_idle();
    rdy = 1'b0;
    put_op(5'b00000, 32'h99, 32'h98, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_alu($sformatf("frz.hold%0d", i), 1'b1, 5'b00000, 32'h33, 32'h42, 2'd3);
    end
    rdy = 1'b1;
    flush = 1'b1;
    tick();
    chk_v("flush.valid", 1'b0);
    chk_full("flush.full", 1'b0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_v($sformatf("flush.empty%0d", i), 1'b0);
    end

    // Reset in the middle of operation
    put_op(5'b00011, 32'h21, 32'h22, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1);
    tick();
    put_op(5'b00000, 32'd0, 32'h2, 2'd1, 1'b1, 2'd0, 1'b0, 2'd2);
    tick();
    bus.in_valid = 1'b0;
    chk_alu("rst.pre", 1'b1, 5'b00011, 32'h21, 32'h22, 2'd1);
    rst = 1'b0;
    tick();
    chk_alu("rst.clear", 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
    chk_full("rst.full", 1'b0);
    rst = 1'b1;
    bus.cdb0_valid = 1'b1; bus.cdb0_rob_id = 2'd1; bus.cdb0_value = 32'h7;
    tick();
    cdb_idle();
    tick();
    chk_v("rst.empty", 1'b0);
    put_op(5'b00000, 32'd5, 32'd6, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk_alu("rst.after", 1'b1, 5'b00000, 32'd5, 32'd6, 2'd2);

    // Exactly one deliberate offer to a full station was made.
    chk("proto.full_offer", 32'(viol), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
